// File: rtl/eclk_vpa_seq_if.sv
// Bus-side handshake between the VPA sequencer and the current bus master.
// The master modport is the bus-master side; the slave modport is the sequencer.
interface eclk_vpa_seq_if;
    logic bus_granted;
    logic as_n;
    logic vpa_n;
    logic vma_n;
    logic vma_oe;
    logic vpa_term;

    modport master (
        output bus_granted, as_n, vpa_n,
        input  vma_n, vma_oe, vpa_term
    );

    modport slave (
        input  bus_granted, as_n, vpa_n,
        output vma_n, vma_oe, vpa_term
    );
endinterface

// File: rtl/eclk_vpa_seq.sv
// 68000 E-clock generator/tracker plus the VPA/VMA sequencer that runs
// 6800-style peripheral cycles locked to the E period.
module eclk_vpa_seq #(
    parameter int E_LOW  = 6,
    parameter int E_HIGH = 4
) (
    input  logic                 M68K_CLK,
    input  logic                 M68K_RESET_n,
    input  logic                 e_drive,
    input  logic                 e_sense,
    eclk_vpa_seq_if.slave        bus,
    output logic                 e_out,
    output logic                 e_oe,
    output logic [3:0]           e_phase
);

    localparam logic [3:0] CNT_LAST = 4'(E_LOW + E_HIGH - 1);
    localparam logic [3:0] CNT_HIGH = 4'(E_LOW);
    localparam logic [3:0] CNT_SYNC = 4'(E_LOW + 2);
    localparam logic [3:0] CNT_VMA  = 4'(E_LOW - 3);
    localparam logic [3:0] CNT_TERM = 4'(E_LOW + E_HIGH - 2);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_SYNC = 2'd1;
    localparam logic [1:0] VMA       = 2'd2;
    localparam logic [1:0] TERM      = 2'd3;

    logic [3:0] e_cnt;
    logic [3:0] cnt_next;
    logic [1:0] sync_q;
    logic       e_rise;
    logic [1:0] state;
    logic [1:0] state_next;
    logic       abort;

    // The rise is seen as it moves into the second stage; loading E_LOW+2 on
    // that edge makes up for the two clocks spent in the synchronizer.
    assign e_rise = sync_q[0] & ~sync_q[1];

    assign abort = bus.as_n | ~bus.bus_granted;

    assign e_oe       = e_drive;
    assign bus.vma_oe = bus.bus_granted;
    assign e_phase    = e_cnt;

    always_comb begin
        if (!e_drive && e_rise) begin
            cnt_next = CNT_SYNC;
        end else if (e_cnt == CNT_LAST) begin
            cnt_next = '0;
        end else begin
            cnt_next = e_cnt + 4'd1;
        end
    end

    // NOTE: every signal written here gets a value on every path (default
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.bus_granted && !bus.as_n && !bus.vpa_n) begin
                    state_next = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (e_cnt == CNT_VMA) begin
                    state_next = VMA;
                end
            end
            VMA: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (e_cnt == CNT_TERM) begin
                    state_next = TERM;
                end
            end
            TERM: begin
                if (bus.as_n) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            e_cnt  <= '0;
            e_out  <= 1'b0;
            sync_q <= '0;
        end else begin
            e_cnt  <= cnt_next;
            e_out  <= (cnt_next >= CNT_HIGH);
            sync_q <= {sync_q[0], e_sense};
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the transition and never glitch.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state        <= IDLE;
            bus.vma_n    <= 1'b1;
            bus.vpa_term <= 1'b0;
        end else begin
            state        <= state_next;
            bus.vma_n    <= !((state_next == VMA) || (state_next == TERM));
            bus.vpa_term <= (state_next == TERM);
        end
    end

endmodule

// File: tb/tb_eclk_vpa_seq.sv
// Self-checking bench for eclk_vpa_seq: directed timing scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_eclk_vpa_seq;

    localparam int E_LOW  = 6;
    localparam int E_HIGH = 4;
    localparam int PERIOD = E_LOW + E_HIGH;

    logic       clk;
    logic       rst_n;
    logic       e_drive;
    logic       e_sense;
    logic       e_out;
    logic       e_oe;
    logic [3:0] e_phase;

    eclk_vpa_seq_if bus_if ();

    eclk_vpa_seq #(.E_LOW(E_LOW), .E_HIGH(E_HIGH)) dut (
        .M68K_CLK     (clk),
        .M68K_RESET_n (rst_n),
        .e_drive      (e_drive),
        .e_sense      (e_sense),
        .bus          (bus_if),
        .e_out        (e_out),
        .e_oe         (e_oe),
        .e_phase      (e_phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: E phase as an integer modulo the period, the sampled
    // E history, and three flags describing how far the peripheral cycle got.
    int m_phase;
    bit m_h1, m_h2;
    bit m_busy, m_vma, m_term;

    // External host E: its own phase counter, E high in the upper part.
    int ext;
    bit ext_run;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_h1 = 1'b0;
        m_h2 = 1'b0;
        m_busy = 1'b0;
        m_vma = 1'b0;
        m_term = 1'b0;
    endfunction

    function automatic void model_edge();
        bit quit;
        quit = bus_if.as_n || !bus_if.bus_granted;
        if (!m_busy) begin
            m_busy = bus_if.bus_granted && !bus_if.as_n && !bus_if.vpa_n;
        end else if (m_term) begin
            if (bus_if.as_n) begin
                m_busy = 1'b0; m_vma = 1'b0; m_term = 1'b0;
            end
        end else if (quit) begin
            m_busy = 1'b0; m_vma = 1'b0;
        end else if (!m_vma) begin
            m_vma = (m_phase == E_LOW - 3);
        end else begin
            m_term = (m_phase == PERIOD - 2);
        end

        if (!e_drive && m_h1 && !m_h2) m_phase = E_LOW + 2;
        else m_phase = (m_phase + 1) % PERIOD;
        m_h2 = m_h1;
        m_h1 = e_sense;
    endfunction

    task automatic compare_model();
        check("e_out",    8'(e_out),           8'(m_phase >= E_LOW));
        check("e_phase",  8'(e_phase),         8'(m_phase));
        check("vma_n",    8'(bus_if.vma_n),    8'(!m_vma));
        check("vpa_term", 8'(bus_if.vpa_term), 8'(m_term));
        check("e_oe",     8'(e_oe),            8'(e_drive));
        check("vma_oe",   8'(bus_if.vma_oe),   8'(bus_if.bus_granted));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (ext_run) begin
            ext = (ext + 1) % PERIOD;
            e_sense = (ext >= E_LOW);
        end
        compare_model();
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (m_phase != p && n < 3 * PERIOD) begin
            step();
            n++;
        end
        check("wait_phase", 8'(e_phase), 8'(p));
    endtask

    // Full VPA cycle sampled at phase 1, ended by as_n two clocks after TERM.
    task automatic vpa_cycle(input string tag);
        wait_phase(1);
        bus_if.bus_granted = 1'b1;
        bus_if.as_n = 1'b0;
        bus_if.vpa_n = 1'b0;
        step();
        step();
        check({tag, "_vma_early"}, 8'(bus_if.vma_n), 8'd1);
        step();
        check({tag, "_vma_phase"}, 8'(e_phase), 8'd4);
        check({tag, "_vma_on"}, 8'(bus_if.vma_n), 8'd0);
        bus_if.vpa_n = 1'b1;
        repeat (4) step();
        check({tag, "_term_early"}, 8'(bus_if.vpa_term), 8'd0);
        step();
        check({tag, "_term_phase"}, 8'(e_phase), 8'd9);
        check({tag, "_term_on"}, 8'(bus_if.vpa_term), 8'd1);
        check({tag, "_e_high"}, 8'(e_out), 8'd1);
        step();
        check({tag, "_e_fall"}, 8'(e_out), 8'd0);
        check({tag, "_term_hold"}, 8'(bus_if.vpa_term), 8'd1);
        step();
        bus_if.as_n = 1'b1;
        step();
        check({tag, "_vma_off"}, 8'(bus_if.vma_n), 8'd1);
        check({tag, "_term_off"}, 8'(bus_if.vpa_term), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int highs, rises, n, hold;
        logic prev;

        rst_n = 1'b0;
        e_drive = 1'b1;
        e_sense = 1'b0;
        ext = 0;
        ext_run = 1'b0;
        bus_if.bus_granted = 1'b1;
        bus_if.as_n = 1'b1;
        bus_if.vpa_n = 1'b1;
        model_reset();

        // Reset state, held across two clock edges.
        #22;
        check("rst_e_out", 8'(e_out), 8'd0);
        check("rst_phase", 8'(e_phase), 8'd0);
        check("rst_vma_n", 8'(bus_if.vma_n), 8'd1);
        check("rst_term", 8'(bus_if.vpa_term), 8'd0);
        rst_n = 1'b1;

        // Counting starts on the first edge; E rises on the sixth.
        for (int k = 1; k <= 6; k++) begin
            step();
            check("post_rst_phase", 8'(e_phase), 8'(k));
            check("post_rst_e_out", 8'(e_out), 8'(k >= 6));
        end

        // Free run: one full period is 6 low / 4 high with one rise, wrap 9->0.
        wait_phase(9);
        highs = 0;
        rises = 0;
        prev = e_out;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            if (i == 0) check("wrap_to_0", 8'(e_phase), 8'd0);
            if (e_out === 1'b1) highs++;
            if (e_out === 1'b1 && prev === 1'b0) rises++;
            prev = e_out;
        end
        check("period_highs", 8'(highs), 8'd4);
        check("period_rises", 8'(rises), 8'd1);
        check("period_end", 8'(e_phase), 8'd9);

        vpa_cycle("gen");

        // Back-to-back: as_n low again straight after TERM->IDLE.
        bus_if.as_n = 1'b0;
        bus_if.vpa_n = 1'b0;
        step();
        bus_if.vpa_n = 1'b1;
        n = 0;
        while (bus_if.vma_n !== 1'b0 && n < 3 * PERIOD) begin
            step();
            n++;
        end
        check("b2b_vma_phase", 8'(e_phase), 8'd4);
        bus_if.as_n = 1'b1;
        step();

        // Late arrival at phase 5 waits for the next period.
        wait_phase(5);
        bus_if.as_n = 1'b0;
        bus_if.vpa_n = 1'b0;
        n = 0;
        while (bus_if.vma_n !== 1'b0 && n < 3 * PERIOD) begin
            step();
            n++;
        end
        check("late_delay", 8'(n), 8'd9);
        check("late_phase", 8'(e_phase), 8'd4);
        bus_if.as_n = 1'b1;
        bus_if.vpa_n = 1'b1;
        step();

        // Abort from VMA: back to IDLE, no termination.
        wait_phase(1);
        bus_if.as_n = 1'b0;
        bus_if.vpa_n = 1'b0;
        repeat (3) step();
        check("abort_vma_on", 8'(bus_if.vma_n), 8'd0);
        bus_if.as_n = 1'b1;
        bus_if.vpa_n = 1'b1;
        step();
        check("abort_vma_off", 8'(bus_if.vma_n), 8'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            check("abort_no_term", 8'(bus_if.vpa_term), 8'd0);
        end

        // Tracking mode: external E rises at an arbitrary local phase.
        e_drive = 1'b0;
        e_sense = 1'b0;
        repeat ($urandom_range(3, 12)) step();
        #($urandom_range(0, 6));
        e_sense = 1'b1;
        ext = E_LOW;
        ext_run = 1'b1;
        step();
        step();
        check("track_phase", 8'(e_phase), 8'd8);
        vpa_cycle("trk");
        ext_run = 1'b0;
        e_drive = 1'b1;

        // Reset pulse during TERM, then a normal cycle after release.
        wait_phase(1);
        bus_if.as_n = 1'b0;
        bus_if.vpa_n = 1'b0;
        repeat (8) step();
        check("rst_term_before", 8'(bus_if.vpa_term), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_term_async", 8'(bus_if.vpa_term), 8'd0);
        check("rst_vma_async", 8'(bus_if.vma_n), 8'd1);
        check("rst_e_async", 8'(e_out), 8'd0);
        check("rst_phase_async", 8'(e_phase), 8'd0);
        bus_if.as_n = 1'b1;
        bus_if.vpa_n = 1'b1;
        step();
        #3 rst_n = 1'b1;
        vpa_cycle("post_rst");

        // Randomized traffic with mode switches and re-phased external E.
        ext_run = 1'b1;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) e_drive = ~e_drive;
            if ($urandom_range(0, 39) == 0) ext = $urandom_range(0, PERIOD - 1);
            bus_if.bus_granted = ($urandom_range(0, 19) != 0);
            if (hold == 0) begin
                bus_if.as_n = $urandom_range(0, 2) == 0;
                hold = $urandom_range(1, 20);
            end else begin
                hold--;
            end
            bus_if.vpa_n = $urandom_range(0, 1) == 1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eclk_vpa_seq.md
ECLK_VPA_SEQ -- requirements
Module: eclk_vpa_seq

Interface
REQ-001 Parameter E_LOW, default 6, M68K_CLK cycles E is low per period.
REQ-002 Parameter E_HIGH, default 4, M68K_CLK cycles E is high per period.
REQ-003 M68K_CLK  input  1  bus clock (7 MHz); all state on its rising edge.
REQ-004 M68K_RESET_n  input  1  reset, asynchronous, active-low.
REQ-005 e_drive  input  1  1 = this block generates E; 0 = the host 68000 drives E and this block tracks it.
REQ-006 e_sense  input  1  E pin as seen on the bus, asynchronous.
REQ-007 bus_granted  input  1  bus owned by the Pi-side master; gates VPA cycles.
REQ-008 as_n  input  1  address strobe of the current master's cycle.
REQ-009 vpa_n  input  1  valid peripheral address from the motherboard.
REQ-010 e_out  output  1  generated E clock.
REQ-011 e_oe  output  1  enable for the E pin driver; equals e_drive.
REQ-012 vma_n  output  1  valid memory address to 6800-type peripherals.
REQ-013 vma_oe  output  1  enable for the VMA pin driver; equals bus_granted.
REQ-014 vpa_term  output  1  cycle termination to the bus state machine; behaves as DTACK.
REQ-015 e_phase  output  4  current E counter value, for debug and test.

Function
REQ-016 Counter e_cnt SHALL count 0..E_LOW+E_HIGH-1, +1 per clock, and wrap to 0.
REQ-017 e_out SHALL be registered 1 iff e_cnt >= E_LOW: 6 clocks low, 4 clocks high at defaults.
REQ-018 Tracking mode (e_drive=0): e_sense SHALL pass a 2-flop synchronizer.
REQ-019 In tracking mode, a detected synchronized rising edge SHALL load e_cnt with E_LOW+2, compensating synchronizer latency; otherwise normal counting.
REQ-020 A change of e_drive SHALL take effect on the next edge with no counter reset.
REQ-021 as_n and vpa_n SHALL be sampled on the rising edge with no extra synchronizer, since they are synchronous to M68K_CLK.
REQ-022 State machine states: IDLE, WAIT_SYNC, VMA, TERM.
REQ-023 IDLE->WAIT_SYNC when bus_granted=1, as_n=0 and vpa_n=0 are sampled together.
REQ-024 WAIT_SYNC->VMA on the edge where e_cnt==E_LOW-3; vma_n goes 0 on that edge.
REQ-025 A VPA cycle arriving after the E_LOW-3 point of the current period SHALL wait for the next period.
REQ-026 VMA->TERM on the edge where e_cnt==E_LOW+E_HIGH-2; vpa_term goes 1 on that edge, so E falls one clock later.
REQ-027 TERM->IDLE on the first edge where as_n is sampled 1; vma_n and vpa_term go 1/0 on that edge.
REQ-028 Abort: as_n sampled 1, or bus_granted sampled 0, in WAIT_SYNC or VMA SHALL return to IDLE with vma_n=1 and vpa_term=0 on that edge.
REQ-029 vpa_n deasserting after WAIT_SYNC entry SHALL NOT abort the cycle; only as_n and bus_granted abort.
REQ-030 Back-to-back cycles: as_n low again directly after TERM->IDLE SHALL be accepted from IDLE on the following edge.
REQ-031 vma_n SHALL be 0 only in VMA and TERM; vpa_term SHALL be 1 only in TERM.

Reset
REQ-032 While M68K_RESET_n=0, asynchronously: e_cnt=0, e_out=0, state=IDLE, vma_n=1, vpa_term=0, synchronizer flops=0.
REQ-033 Reset asserted mid-cycle SHALL abandon the cycle immediately, with no termination pulse.
REQ-034 After reset release, counting SHALL start on the first rising edge; e_out first goes high 6 edges after release.

Verification
REQ-035 Free run, e_drive=1, default parameters -> e_out period exactly 10 clocks, 6 low/4 high; e_phase wraps 9->0.
REQ-036 e_drive=1; as_n=0 and vpa_n=0 sampled at e_cnt=1 -> vma_n=0 at e_cnt=4, vpa_term=1 at e_cnt=9; as_n=1 two clocks later -> IDLE, vma_n=1.
REQ-037 VPA cycle sampled at e_cnt=5 -> no VMA until the next period: vma_n=0 at the following e_cnt=4, 9 clocks later.
REQ-038 e_drive=0, external E rising at an arbitrary phase -> e_phase=8 two clocks after the edge; cycle timing of REQ-036 holds relative to external E.
REQ-039 as_n=1 during the VMA state -> IDLE next edge, vma_n=1, vpa_term never asserted.
REQ-040 Reset pulse during TERM -> vpa_term=0, vma_n=1, e_out=0 asynchronously; normal cycle completes after release.
